// File: rtl/gf2_affine_31_pkg.sv
// Shared constants and FSM state type for the serial inverse of the
// GF(2) affine map q(x) = (x^4 + 1) p(x) + 1 over 31-bit p(x).
package gf2_affine_31_pkg;

   localparam int P_W   = 31;                  // width of the pre-image p(x)
   localparam int Q_W   = 35;                  // width of the image q(x)
   localparam int A_DEG = 4;                   // degree of a(x)
   localparam int CNT_W = 5;                   // quotient bit index width

   localparam logic [A_DEG:0]   A_POLY  = 5'b10001;   // a(x) = x^4 + 1
   localparam logic [Q_W-1:0]   C_POLY  = 35'd1;      // c(x) = 1
   localparam logic [CNT_W-1:0] CNT_MAX = 5'd30;      // highest quotient bit

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/gf2_div_step_x4p1.sv
// One combinational step of long division by a(x) = x^4 + 1.
// The quotient bit for position cnt is the remainder coefficient at
// cnt + A_DEG; when it is set, a(x) shifted by cnt is subtracted (XORed).
module gf2_div_step_x4p1
   import gf2_affine_31_pkg::*;
(
   input  logic [Q_W-1:0]   i_rem,
   input  logic [CNT_W-1:0] i_cnt,
   output logic [Q_W-1:0]   o_rem,
   output logic             o_qbit
);

   localparam logic [Q_W-1:0] L_ONE = 35'd1;

   logic [5:0]     w_top_idx;
   logic [Q_W-1:0] w_top_shift;
   logic [Q_W-1:0] w_mask;

   // Select the leading coefficient and build the shifted divisor mask.
   always_comb begin
      w_top_idx   = {1'b0, i_cnt} + 6'd4;
      w_top_shift = i_rem >> w_top_idx;
      o_qbit      = w_top_shift[0];
      w_mask      = '0;
      for (int k = 0; k <= A_DEG; k++) begin
         if (A_POLY[k]) begin
            w_mask = w_mask | (L_ONE << ({1'b0, i_cnt} + 6'(k)));
         end else begin
            w_mask = w_mask;
         end
      end
      if (o_qbit) begin
         o_rem = i_rem ^ w_mask;
      end else begin
         o_rem = i_rem;
      end
   end

endmodule

// File: rtl/gf2_poly_affine_inv_31.sv
// Serial inverse of q(x) = (x^4 + 1) p(x) + 1: strips c(x) and divides by
// a(x) one quotient bit per cycle (31 cycles), then holds the result until
// the consumer accepts it. Defining GF2_AFFINE_INV_ERR_EN adds out_err,
// flagging a nonzero division remainder (input was not a valid image).
module gf2_poly_affine_inv_31
   import gf2_affine_31_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [Q_W-1:0]  in_poly,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [P_W-1:0]  out_poly
`ifdef GF2_AFFINE_INV_ERR_EN
   ,
   output logic            out_err
`endif
);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [Q_W-1:0]   r_rem;
   logic [P_W-1:0]   r_quo;
   logic             r_out_valid;
   logic [P_W-1:0]   r_out_poly;
`ifdef GF2_AFFINE_INV_ERR_EN
   logic             r_out_err;
`endif

   logic [Q_W-1:0]   w_next_rem;
   logic             w_qbit;

   gf2_div_step_x4p1 u_step (
      .i_rem  (r_rem),
      .i_cnt  (r_cnt),
      .o_rem  (w_next_rem),
      .o_qbit (w_qbit)
   );

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign out_poly  = r_out_poly;
`ifdef GF2_AFFINE_INV_ERR_EN
   assign out_err   = r_out_err;
`endif

   // Control FSM, division datapath and registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_out_valid <= 1'b0;
         r_out_poly  <= '0;
`ifdef GF2_AFFINE_INV_ERR_EN
         r_out_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_rem   <= in_poly ^ C_POLY;
                  r_cnt   <= CNT_MAX;
                  r_quo   <= '0;
                  r_state <= DIV;
               end else begin
                  r_state <= IDLE;
               end
            end
            DIV: begin
               r_rem        <= w_next_rem;
               r_quo[r_cnt] <= w_qbit;
               if (r_cnt == 5'd0) begin
                  // Final step: bit 0 of the quotient comes straight from the step.
                  r_out_poly  <= {r_quo[P_W-1:1], w_qbit};
                  r_out_valid <= 1'b1;
`ifdef GF2_AFFINE_INV_ERR_EN
                  r_out_err   <= |w_next_rem[A_DEG-1:0];
`endif
                  r_state     <= DONE;
               end else begin
                  r_cnt <= r_cnt - 5'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end else begin
                  r_state <= DONE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf2_poly_affine_inv_31.sv
// Self-checking bench for gf2_poly_affine_inv_31: directed vectors, latency,
// backpressure, mid-operation reset and a randomized regression against a
// polynomial long-division reference model. Honors GF2_AFFINE_INV_ERR_EN.
module tb_gf2_poly_affine_inv_31;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [34:0] in_poly;
   logic        out_valid;
   logic        out_ready;
   logic [30:0] out_poly;
`ifdef GF2_AFFINE_INV_ERR_EN
   logic        out_err;
`endif

   int checks = 0;
   int errors = 0;

   gf2_poly_affine_inv_31 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_poly   (in_poly),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_poly  (out_poly)
`ifdef GF2_AFFINE_INV_ERR_EN
      ,
      .out_err   (out_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: schoolbook division of (q + 1) by x^4 + 1 over GF(2).
   task automatic ref_inv(input logic [34:0] q, output logic [30:0] p, output logic err);
      logic [63:0] r;
      logic [63:0] quo;
      r   = {29'd0, q} ^ 64'd1;
      quo = 64'd0;
      for (int d = 34; d >= 4; d--) begin
         if (r[d]) begin
            r        = r ^ (64'h11 << (d - 4));
            quo[d-4] = 1'b1;
         end
      end
      p   = quo[30:0];
      err = (r != 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [34:0] q, input int bp,
                         input bit hold_valid, input bit chk_lat);
      logic [30:0] ep;
      logic        ee;
      logic [30:0] held;
      int          j;
      ref_inv(q, ep, ee);
      @(negedge clk);
      check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_poly  = q;
      @(posedge clk);
      #1;
      in_valid = hold_valid;
      in_poly  = {$urandom_range(7, 0), $urandom};
      j = 1;
      @(posedge clk);
      #1;
      while (!out_valid && j < 40) begin
         j++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (chk_lat) check({tag, "_latency"}, 64'(j), 64'd31);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_out_poly"}, 64'(out_poly), 64'(ep));
`ifdef GF2_AFFINE_INV_ERR_EN
      check({tag, "_out_err"}, 64'(out_err), 64'(ee));
`endif
      check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      held = out_poly;
      for (int k = 0; k < bp; k++) begin
         @(negedge clk);
         check({tag, "_bp_valid"}, 64'(out_valid), 64'd1);
         check({tag, "_bp_poly"}, 64'(out_poly), 64'(held));
         check({tag, "_bp_in_ready"}, 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_hs_valid_low"}, 64'(out_valid), 64'd0);
      check({tag, "_hs_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [30:0] p;
      logic [34:0] q;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_poly   = 35'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_poly", 64'(out_poly), 64'd0);
`ifdef GF2_AFFINE_INV_ERR_EN
      check("rst_out_err", 64'(out_err), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, with explicit expected values.
      run_op("q1", 35'h1, 0, 1'b0, 1'b1);
      check("q1_const", 64'(out_poly), 64'd0);
      run_op("q10", 35'h10, 0, 1'b0, 1'b1);
      check("q10_const", 64'(out_poly), 64'd1);
      run_op("qmax", 35'h7_8000_000E, 0, 1'b0, 1'b1);
      check("qmax_const", 64'(out_poly), 64'h7FFF_FFFF);
      run_op("q0", 35'h0, 0, 1'b0, 1'b1);
      check("q0_const", 64'(out_poly), 64'd0);

      // Backpressure for 10 cycles, then in_valid held high through DIV.
      run_op("bp10", 35'h5_A5A5_A5A5, 10, 1'b0, 1'b1);
      run_op("hold", 35'h1_2345_6789, 0, 1'b1, 1'b1);

      // Reset in the middle of DIV.
      @(negedge clk);
      in_valid = 1'b1;
      in_poly  = 35'h3_0000_0000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_poly", 64'(out_poly), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (35) @(negedge clk);
      check("midrst_no_result", 64'(out_valid), 64'd0);
      run_op("after_rst", 35'h10, 0, 1'b0, 1'b1);
      check("after_rst_const", 64'(out_poly), 64'd1);

      // Random valid images: p recovered exactly, no error.
      for (int i = 0; i < 12; i++) begin
         p = 31'($urandom);
         q = ({4'd0, p} << 4) ^ {4'd0, p} ^ 35'd1;
         run_op("rnd_img", q, $urandom_range(3, 0), 1'($urandom_range(1, 0)), 1'b0);
         check("rnd_img_p", 64'(out_poly), 64'(p));
      end

      // Random arbitrary inputs checked against the division model.
      for (int i = 0; i < 8; i++) begin
         q = {$urandom_range(7, 0), $urandom};
         run_op("rnd_any", q, $urandom_range(2, 0), 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
